pipe_regfile_mp: RTL and testbench
==================================

// Module: pipe_regfile_mp
// PURPOSE
// Parametrised multi-read-port GPR file with HI/LO pair for the pipelined MIPS datapath.
// Sits between ID (read addresses) and WB (write-back).
// Registered reads with write-first bypass, so an ID read of a WB-written reg sees the new value.
// Sequential post-reset clear FSM so the array can map to FPGA distributed/block RAM.
// Adds mthi/mtlo-style single-half writes alongside the 2*DATA_W mult/div product write.
// PARAMETERS
// DATA_W   32  register width in bits
// ADDR_W    5  GPR address width
// NUM_GPR  32  number of GPRs (<= 2**ADDR_W); reg 0 hardwired to zero
// NUM_RD    2  number of read ports
// PORTS
// clock       in   1              rising-edge clock
// reset       in   1              synchronous, active-high reset
// ready       out  1              1 = clear finished, accesses honoured
// wr_en       in   1              GPR write enable (WB stage)
// wr_addr     in   ADDR_W         GPR write address
// wr_data     in   DATA_W         GPR write data
// hilo_we     in   1              write {HI,LO} <= hilo_prod (mult/div)
// hilo_prod   in   2*DATA_W       product/quotient pair, [2W-1:W] -> HI
// hi_we       in   1              write HI <= hl_wdata (mthi)
// lo_we       in   1              write LO <= hl_wdata (mtlo)
// hl_wdata    in   DATA_W         data for hi_we/lo_we
// rd_addr     in   NUM_RD*ADDR_W  read addresses, port k at [k*ADDR_W +: ADDR_W]
// rd_data     out  NUM_RD*DATA_W  registered read data, port k at [k*DATA_W +: DATA_W]
// hi_out      out  DATA_W         registered HI
// lo_out      out  DATA_W         registered LO
// BEHAVIOUR
// - FSM: CLEAR, READY.
//   - reset=1 at a posedge -> CLEAR, clr_idx=0; HI, LO, rd_data, hi_out, lo_out <= 0; ready <= 0.
// - CLEAR:
//   - Writes 0 to GPR[clr_idx] and increments clr_idx each cycle.
//   - All write enables ignored; rd_data, hi_out, lo_out held at 0.
//   - Entering CLEAR at clr_idx==NUM_GPR-1 -> READY next edge; ready=1 exactly NUM_GPR cycles after reset deasserts.
// - reset mid-CLEAR or in READY restarts CLEAR at clr_idx=0; reset dominates all other inputs.
// - READY, GPR write:
//   - wr_en && wr_addr!=0 && wr_addr<NUM_GPR writes GPR at posedge.
//   - Writes to addr 0 or out-of-range addresses are dropped.
// - READY, HI/LO writes:
//   - hilo_we has priority: HI/LO both loaded from hilo_prod, and hi_we/lo_we are ignored that cycle.
//   - Otherwise hi_we and lo_we act independently; both may fire in one cycle.
// - Read latency is 1 cycle: rd_data port k <= value of GPR[rd_addr_k] at each posedge.
//   - Addr 0 or out-of-range returns 0.
//   - Bypass: if wr_en with a legal wr_addr equal to rd_addr_k in the same cycle, return wr_data (write-first).
//   - All ports bypass independently; several ports may read the same address.
// - hi_out/lo_out are registered with the same bypass: next HI/LO value after this edge's writes.
// - No combinational path from inputs to outputs.
// TESTING
// - Reset 1 cycle, then idle -> ready=0 for 32 cycles, ready=1 on cycle 32; every rd_data, hi_out, lo_out = 0.
// - wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, rd_addr0=5 same cycle -> rd_data0=0xDEADBEEF next cycle; reading 5 later is stable.
// - wr_en=1, wr_addr=0, wr_data=0x1234, rd_addr0=rd_addr1=0 -> both ports return 0 in the same and the following cycle.
// - hilo_we=1, hilo_prod=0x00000001_FFFFFFFE, hi_we=1, hl_wdata=0x55 -> hi_out=1, lo_out=0xFFFFFFFE.
//   - Next cycle lo_we=1, hl_wdata=0x77 -> lo_out=0x77, hi_out=1.
// - Write r7=0xA5 in READY, then assert reset at clear cycle 10 -> clear restarts at 0.
//   - ready rises 32 cycles after the second reset; r7 reads 0; wr_en during CLEAR leaves the target reg 0.
// - NUM_RD=3, DATA_W=16: write r3=0xBEEF, r4=0x0001 -> rd_addr {3,4,3} returns {0xBEEF,0x0001,0xBEEF}.

Source files
------------

// File: rtl/pipe_regfile_mp.sv
// Multi-read-port GPR file with HI/LO pair for the pipelined MIPS datapath.
// Registered, write-first reads; a post-reset FSM clears the array one entry per cycle.
module pipe_regfile_mp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_GPR = 32,
    parameter int NUM_RD  = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     ready,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     hilo_we,
    input  logic [2*DATA_W-1:0]      hilo_prod,
    input  logic                     hi_we,
    input  logic                     lo_we,
    input  logic [DATA_W-1:0]        hl_wdata,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0]        hi_out,
    output logic [DATA_W-1:0]        lo_out
);

    typedef enum logic {CLEAR, READY} state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   clr_idx;
    logic [DATA_W-1:0]   gpr [NUM_GPR];
    logic [DATA_W-1:0]   hi_next, lo_next;
    logic [NUM_RD*DATA_W-1:0] rd_next;
    logic                wr_legal;

    // Register 0 and addresses beyond the populated range never hold data.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a != '0) && (32'(a) < NUM_GPR);
    endfunction

    assign wr_legal = (state == READY) && wr_en && addr_ok(wr_addr);

    // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        if (state == CLEAR && clr_idx == ADDR_W'(NUM_GPR - 1))
            state_next = READY;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= CLEAR;
            clr_idx <= '0;
            ready   <= 1'b0;
        end else begin
            state <= state_next;
            ready <= (state_next == READY);
            if (state == CLEAR)
                clr_idx <= clr_idx + 1'b1;
        end
    end

    // NOTE: the array has no reset term so it can map onto RAM; the CLEAR walk zeroes it instead.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == CLEAR)
                gpr[clr_idx] <= '0;
            else if (wr_legal)
                gpr[wr_addr] <= wr_data;
        end
    end

    // HI/LO outputs are the registers themselves, so they already show the post-write value.
    always_comb begin
        hi_next = hi_out;
        lo_next = lo_out;
        if (state == READY) begin
            if (hilo_we) begin
                hi_next = hilo_prod[2*DATA_W-1:DATA_W];
                lo_next = hilo_prod[DATA_W-1:0];
            end else begin
                if (hi_we) hi_next = hl_wdata;
                if (lo_we) lo_next = hl_wdata;
            end
        end
    end

    always_comb begin
        rd_next = '0;
        if (state == READY) begin
            for (int k = 0; k < NUM_RD; k++) begin
                if (wr_legal && wr_addr == rd_addr[k*ADDR_W +: ADDR_W])
                    rd_next[k*DATA_W +: DATA_W] = wr_data;
                else if (addr_ok(rd_addr[k*ADDR_W +: ADDR_W]))
                    rd_next[k*DATA_W +: DATA_W] = gpr[rd_addr[k*ADDR_W +: ADDR_W]];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            hi_out  <= '0;
            lo_out  <= '0;
            rd_data <= '0;
        end else begin
            hi_out  <= hi_next;
            lo_out  <= lo_next;
            rd_data <= rd_next;
        end
    end

endmodule

// File: tb/tb_pipe_regfile_mp.sv
// Directed bench for pipe_regfile_mp: a default instance and a 3-port 16-bit instance
// with 20 GPRs; expected outputs are queued per cycle and checked after each edge.
module tb_pipe_regfile_mp;

    logic        clock = 1'b0;
    logic        reset;

    logic        ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        hilo_we;
    logic [63:0] hilo_prod;
    logic        hi_we, lo_we;
    logic [31:0] hl_wdata;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [31:0] hi_out, lo_out;

    logic        ready2;
    logic        wr_en2;
    logic [4:0]  wr_addr2;
    logic [15:0] wr_data2;
    logic        hilo_we2, hi_we2, lo_we2;
    logic [31:0] hilo_prod2;
    logic [15:0] hl_wdata2;
    logic [14:0] rd_addr2;
    logic [47:0] rd_data2;
    logic [15:0] hi_out2, lo_out2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          which;
        logic [63:0] value;
        string       tag;
    } exp_t;

    exp_t sb[$];

    always #5 clock = ~clock;

    pipe_regfile_mp dut (
        .clock(clock), .reset(reset), .ready(ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .hilo_we(hilo_we), .hilo_prod(hilo_prod),
        .hi_we(hi_we), .lo_we(lo_we), .hl_wdata(hl_wdata),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .hi_out(hi_out), .lo_out(lo_out)
    );

    pipe_regfile_mp #(.DATA_W(16), .ADDR_W(5), .NUM_GPR(20), .NUM_RD(3)) dut2 (
        .clock(clock), .reset(reset), .ready(ready2),
        .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
        .hilo_we(hilo_we2), .hilo_prod(hilo_prod2),
        .hi_we(hi_we2), .lo_we(lo_we2), .hl_wdata(hl_wdata2),
        .rd_addr(rd_addr2), .rd_data(rd_data2),
        .hi_out(hi_out2), .lo_out(lo_out2)
    );

    function automatic logic [63:0] observe(input int which);
        case (which)
            0:       return 64'(ready);
            1:       return 64'(rd_data[31:0]);
            2:       return 64'(rd_data[63:32]);
            3:       return 64'(hi_out);
            4:       return 64'(lo_out);
            5:       return 64'(ready2);
            6:       return 64'(rd_data2[15:0]);
            7:       return 64'(rd_data2[31:16]);
            8:       return 64'(rd_data2[47:32]);
            default: return 64'hx;
        endcase
    endfunction

    task automatic expect_out(input int which, input logic [63:0] value, input string tag);
        exp_t e;
        e.which = which;
        e.value = value;
        e.tag   = tag;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t        e;
        logic [63:0] obs;
        @(posedge clock);
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.which);
            checks++;
            assert (obs === e.value) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.value);
            end
        end
    endtask

    task automatic expect_all_zero(input string tag);
        expect_out(0, 64'd0, {tag, "_ready"});
        expect_out(1, 64'd0, {tag, "_rd0"});
        expect_out(2, 64'd0, {tag, "_rd1"});
        expect_out(3, 64'd0, {tag, "_hi"});
        expect_out(4, 64'd0, {tag, "_lo"});
        expect_out(5, 64'd0, {tag, "_ready2"});
        expect_out(6, 64'd0, {tag, "_rd2_0"});
        expect_out(7, 64'd0, {tag, "_rd2_1"});
        expect_out(8, 64'd0, {tag, "_rd2_2"});
    endtask

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0; wr_addr  = '0; wr_data  = '0;
        hilo_we = 1'b0; hilo_prod = '0; hi_we = 1'b0; lo_we = 1'b0; hl_wdata = '0;
        rd_addr = '0;
        wr_en2   = 1'b0; wr_addr2 = '0; wr_data2 = '0;
        hilo_we2 = 1'b0; hilo_prod2 = '0; hi_we2 = 1'b0; lo_we2 = 1'b0; hl_wdata2 = '0;
        rd_addr2 = '0;

        // Reset, then the clear walk with writes that must be ignored.
        expect_all_zero("reset");
        tick();
        reset    = 1'b0;
        wr_en    = 1'b1; wr_addr = 5'd5; wr_data = 32'h0BAD_0BAD;
        hi_we    = 1'b1; hl_wdata = 32'h1111;
        rd_addr  = {5'd5, 5'd5};
        for (int i = 1; i <= 32; i++) begin
            expect_out(0, 64'(i == 32), "clear1_ready");
            expect_out(5, 64'(i >= 20), "clear1_ready2");
            expect_out(1, 64'd0, "clear1_rd0");
            expect_out(3, 64'd0, "clear1_hi");
            tick();
        end
        wr_en = 1'b0; hi_we = 1'b0;

        // GPR write with same-cycle read: bypass, then stable array read.
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF; rd_addr = {5'd6, 5'd5};
        expect_out(1, 64'hDEAD_BEEF, "bypass_rd0");
        expect_out(2, 64'd0, "cleared_r6_rd1");
        tick();
        wr_en = 1'b0; rd_addr = {5'd5, 5'd5};
        expect_out(1, 64'hDEAD_BEEF, "stable_rd0");
        expect_out(2, 64'hDEAD_BEEF, "stable_rd1");
        tick();
        expect_out(1, 64'hDEAD_BEEF, "stable2_rd0");
        tick();

        // Writes to r0 are dropped and r0 always reads 0.
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h1234; rd_addr = {5'd0, 5'd0};
        expect_out(1, 64'd0, "r0_same_rd0");
        expect_out(2, 64'd0, "r0_same_rd1");
        tick();
        wr_en = 1'b0;
        expect_out(1, 64'd0, "r0_next_rd0");
        expect_out(2, 64'd0, "r0_next_rd1");
        tick();

        // HI/LO: product write beats mthi, then mtlo, then both halves together.
        hilo_we = 1'b1; hilo_prod = 64'h0000_0001_FFFF_FFFE; hi_we = 1'b1; hl_wdata = 32'h55;
        expect_out(3, 64'h1, "prod_hi");
        expect_out(4, 64'hFFFF_FFFE, "prod_lo");
        tick();
        hilo_we = 1'b0; hi_we = 1'b0; lo_we = 1'b1; hl_wdata = 32'h77;
        expect_out(3, 64'h1, "mtlo_hi");
        expect_out(4, 64'h77, "mtlo_lo");
        tick();
        hi_we = 1'b1; lo_we = 1'b1; hl_wdata = 32'h99;
        expect_out(3, 64'h99, "both_hi");
        expect_out(4, 64'h99, "both_lo");
        tick();
        hi_we = 1'b0; lo_we = 1'b0;

        // Write r7, then reset in READY and again at clear cycle 10.
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5; rd_addr = {5'd7, 5'd5};
        expect_out(2, 64'hA5, "r7_bypass_rd1");
        expect_out(1, 64'hDEAD_BEEF, "r5_rd0");
        tick();
        wr_en = 1'b0;
        reset = 1'b1;
        expect_all_zero("reset2");
        tick();
        reset = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            expect_out(0, 64'd0, "clear2_ready");
            tick();
        end
        reset = 1'b1;
        expect_out(0, 64'd0, "reset3_ready");
        expect_out(3, 64'd0, "reset3_hi");
        tick();
        reset = 1'b0;
        hi_we = 1'b1; hl_wdata = 32'hAB;
        for (int i = 1; i <= 32; i++) begin
            wr_en   = (i >= 21);
            wr_addr = 5'd9;
            wr_data = 32'h33;
            expect_out(0, 64'(i == 32), "clear3_ready");
            expect_out(5, 64'(i >= 20), "clear3_ready2");
            expect_out(3, 64'd0, "clear3_hi");
            expect_out(2, 64'd0, "clear3_rd1");
            tick();
        end
        wr_en = 1'b0; hi_we = 1'b0;
        rd_addr = {5'd9, 5'd7};
        expect_out(1, 64'd0, "r7_after_clear");
        expect_out(2, 64'd0, "r9_after_clear");
        tick();
        rd_addr = {5'd5, 5'd5};
        expect_out(1, 64'd0, "r5_after_clear");
        tick();

        // Three-port, 16-bit instance with 20 GPRs.
        wr_en2 = 1'b1; wr_addr2 = 5'd3; wr_data2 = 16'hBEEF; rd_addr2 = {5'd3, 5'd3, 5'd3};
        expect_out(6, 64'hBEEF, "w3_rd2_0");
        expect_out(7, 64'hBEEF, "w3_rd2_1");
        expect_out(8, 64'hBEEF, "w3_rd2_2");
        tick();
        wr_addr2 = 5'd4; wr_data2 = 16'h0001; rd_addr2 = {5'd3, 5'd4, 5'd3};
        expect_out(6, 64'hBEEF, "w4_rd2_0");
        expect_out(7, 64'h0001, "w4_rd2_1");
        expect_out(8, 64'hBEEF, "w4_rd2_2");
        tick();
        wr_en2 = 1'b0;
        expect_out(6, 64'hBEEF, "r343_rd2_0");
        expect_out(7, 64'h0001, "r343_rd2_1");
        expect_out(8, 64'hBEEF, "r343_rd2_2");
        tick();
        wr_en2 = 1'b1; wr_addr2 = 5'd25; wr_data2 = 16'h1234; rd_addr2 = {5'd25, 5'd4, 5'd25};
        expect_out(6, 64'd0, "oor_same_rd2_0");
        expect_out(7, 64'h0001, "oor_same_rd2_1");
        expect_out(8, 64'd0, "oor_same_rd2_2");
        tick();
        wr_addr2 = 5'd19; wr_data2 = 16'h0F0F;
        expect_out(6, 64'd0, "oor_next_rd2_0");
        expect_out(8, 64'd0, "oor_next_rd2_2");
        tick();
        wr_en2 = 1'b0; rd_addr2 = {5'd19, 5'd3, 5'd19};
        expect_out(6, 64'h0F0F, "r19_rd2_0");
        expect_out(7, 64'hBEEF, "r3_rd2_1");
        expect_out(8, 64'h0F0F, "r19_rd2_2");
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
